// File: rtl/fifo_unpacker.sv
// fifo_unpacker
//   Drain stage for the register FIFO. Pops one entry_wd-bit entry at a time,
//   holds it, and emits it as ratio beats of out_wd bits on a valid/ready
//   stream, least significant beat first. Beats are framed into packets of
//   pkt_words entries using first/last markers. A wrapping counter reports how
//   many entries have been fully transmitted.
//
//   Handshake: a beat moves when out_valid && out_ready on a rising edge;
//   once out_valid is raised, out_data/out_first/out_last hold steady until
//   that beat is accepted.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head entry (meaningful only while fifo_empty==0)
//   fifo_rd     FIFO pop request (combinational)
//   out_valid   out_data carries a valid beat
//   out_ready   sink accepts the beat this cycle
//   out_data    current beat
//   out_first   beat 0 of word 0 of a packet
//   out_last    final beat of the final word of a packet
//   busy        a word is held or the FIFO is non-empty
//   words_sent  count of fully transmitted entries, modulo 2^stat_wd
module fifo_unpacker #(
   parameter int entry_wd  = 32,
   parameter int out_wd    = 8,
   parameter int ratio     = 4,
   parameter int beat_wd   = 2,
   parameter int pkt_words = 4,
   parameter int pkt_wd    = 2,
   parameter int stat_wd   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_empty,
   input  logic [entry_wd-1:0] fifo_data,
   output logic                fifo_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [out_wd-1:0]   out_data,
   output logic                out_first,
   output logic                out_last,
   output logic                busy,
   output logic [stat_wd-1:0]  words_sent
);

   localparam int n_slots = 2 ** beat_wd;

   logic [entry_wd-1:0] hold_q, hold_d;
   logic                hold_valid_q, hold_valid_d;
   logic [beat_wd-1:0]  beat_cnt_q, beat_cnt_d;
   logic [pkt_wd-1:0]   word_cnt_q, word_cnt_d;
   logic [stat_wd-1:0]  words_sent_q, words_sent_d;

   logic xfer;
   logic last_beat;
   logic last_word;

   // Beat view of the held entry; slots beyond ratio read as zero so the
   // select below never indexes outside the entry.
   logic [out_wd-1:0] beats [n_slots];

   for (genvar i = 0; i < n_slots; i++) begin : g_beats
      if (i < ratio) begin : g_used
         assign beats[i] = hold_q[i*out_wd +: out_wd];
      end else begin : g_unused
         assign beats[i] = '0;
      end
   end

   assign last_beat = (beat_cnt_q == beat_wd'(ratio - 1));
   assign last_word = (word_cnt_q == pkt_wd'(pkt_words - 1));
   assign xfer      = hold_valid_q && out_ready;

   // Pop when idle, or when the final beat of the held word leaves this
   // cycle so the next word follows with no bubble. Reset blocks any pop.
   assign fifo_rd = rst && !fifo_empty && (!hold_valid_q || (xfer && last_beat));

   assign out_valid  = hold_valid_q;
   assign out_data   = beats[beat_cnt_q];
   assign out_first  = hold_valid_q && (beat_cnt_q == '0) && (word_cnt_q == '0);
   assign out_last   = hold_valid_q && last_beat && last_word;
   assign busy       = hold_valid_q || !fifo_empty;
   assign words_sent = words_sent_q;

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      beat_cnt_d   = beat_cnt_q;
      word_cnt_d   = word_cnt_q;
      words_sent_d = words_sent_q;

      if (xfer) begin
         if (last_beat) begin
            words_sent_d = words_sent_q + stat_wd'(1);
            word_cnt_d   = last_word ? '0 : word_cnt_q + pkt_wd'(1);
            hold_valid_d = 1'b0;
            beat_cnt_d   = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + beat_wd'(1);
         end
      end

      // A pop in the same cycle as the last beat reloads the holding register
      // and overrides the release above.
      if (fifo_rd) begin
         hold_d       = fifo_data;
         hold_valid_d = 1'b1;
         beat_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_valid_q <= 1'b0;
         beat_cnt_q   <= '0;
         word_cnt_q   <= '0;
         words_sent_q <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         beat_cnt_q   <= beat_cnt_d;
         word_cnt_q   <= word_cnt_d;
         words_sent_q <= words_sent_d;
      end
   end

   // Data register needs no reset: it is only observed while hold_valid_q is set.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

endmodule

// File: tb/tb_fifo_unpacker.sv
module tb_fifo_unpacker;

   localparam int ENTRY_WD  = 32;
   localparam int OUT_WD    = 8;
   localparam int RATIO     = 4;
   localparam int PKT_WORDS = 4;

   logic              clk;
   logic              rst;
   logic              fifo_empty;
   logic [31:0]       fifo_data;
   logic              out_ready;

   logic              fifo_rd, out_valid, out_first, out_last, busy;
   logic [7:0]        out_data;
   logic [15:0]       words_sent;

   logic              fifo_rd_w, out_valid_w, out_first_w, out_last_w, busy_w;
   logic [7:0]        out_data_w;
   logic [3:0]        words_sent_w;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: entries waiting in the FIFO, beats still expected
   // from the held word, count of beats accepted since reset, words completed.
   logic [31:0] fifo_q[$];
   logic [7:0]  exp_q[$];
   int          rem;
   int          beat_idx;
   int          words;

   logic        prev_stall;
   logic [7:0]  prev_data;
   logic        prev_first, prev_last;

   fifo_unpacker dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_first(out_first), .out_last(out_last),
      .busy(busy), .words_sent(words_sent)
   );

   fifo_unpacker #(.stat_wd(4)) dut_w (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd_w), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_first(out_first_w), .out_last(out_last_w),
      .busy(busy_w), .words_sent(words_sent_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
   // later, then advance the reference model across the rising edge.
   task automatic cycle(input logic rdy, input logic rst_v);
      logic       exp_rd;
      logic       acc;
      logic [31:0] e;
      int         w, b;
      rst        = rst_v;
      out_ready  = rdy;
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() == 0) ? $urandom : fifo_q[0];
      #1;
      exp_rd = rst_v && (fifo_q.size() != 0) && (rem == 0 || (rdy && rem == 1));
      acc    = rst_v && rdy && (rem != 0);
      w = beat_idx / RATIO;
      b = beat_idx % RATIO;
      chk("out_valid", out_valid, rem != 0);
      chk("fifo_rd", fifo_rd, exp_rd);
      chk("busy", busy, (rem != 0) || (fifo_q.size() != 0));
      chk("words_sent", words_sent, words[15:0]);
      chk("words_sent_w", words_sent_w, words[3:0]);
      chk("fifo_rd_w", fifo_rd_w, exp_rd);
      chk("out_first", out_first, (rem != 0) && b == 0 && (w % PKT_WORDS) == 0);
      chk("out_last", out_last, (rem != 0) && b == RATIO-1 && (w % PKT_WORDS) == PKT_WORDS-1);
      if (prev_stall) begin
         chk("stable_data", out_data, prev_data);
         chk("stable_first", out_first, prev_first);
         chk("stable_last", out_last, prev_last);
      end
      if (acc) begin
         chk("out_data", out_data, exp_q.pop_front());
      end
      prev_stall = rst_v && (rem != 0) && !rdy;
      prev_data  = out_data;
      prev_first = out_first;
      prev_last  = out_last;
      @(posedge clk);
      if (!rst_v) begin
         rem = 0;
         exp_q.delete();
         beat_idx = 0;
         words = 0;
         prev_stall = 1'b0;
      end else begin
         if (acc) begin
            rem--;
            beat_idx++;
            if (rem == 0) words++;
         end
         if (exp_rd) begin
            e = fifo_q.pop_front();
            rem = RATIO;
            for (int i = 0; i < RATIO; i++) exp_q.push_back(e[i*OUT_WD +: OUT_WD]);
         end
      end
      @(negedge clk);
   endtask

   // Run until the FIFO and the stage are empty; an expired budget is a failure.
   task automatic drain(input int budget, input bit random_ready);
      int n;
      n = 0;
      while ((rem != 0 || fifo_q.size() != 0) && n < budget) begin
         cycle(random_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1);
         n++;
      end
      chk("drain_timeout", (rem != 0 || fifo_q.size() != 0), 0);
   endtask

   initial begin
      logic [0:0] pat [7];
      rst = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
      rem = 0; beat_idx = 0; words = 0; prev_stall = 1'b0;
      @(negedge clk);

      // Reset then idle.
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      chk("idle_busy", busy, 0);

      // Single word.
      fifo_q.push_back(32'hA1B2C3D4);
      drain(20, 1'b0);
      chk("single_words", words_sent, 1);

      // Packet framing across two packets.
      for (int i = 0; i < 8; i++) fifo_q.push_back(32'(i));
      drain(60, 1'b0);
      chk("framing_words", words_sent, 9);

      // Backpressure pattern on one word.
      fifo_q.push_back(32'h11223344);
      cycle(1'b1, 1'b1);
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      fifo_q.push_back(32'h55667788);
      for (int i = 0; i < 7; i++) cycle(pat[i], 1'b1);
      drain(30, 1'b0);

      // Reset in the middle of a word, with more entries waiting.
      fifo_q.push_back(32'hDEADBEEF);
      fifo_q.push_back(32'hCAFEF00D);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      chk("post_reset_valid", out_valid, 0);
      drain(30, 1'b0);

      // Counter wrap on the narrow instance: 17 words after reset.
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 17; i++) fifo_q.push_back($urandom);
      drain(200, 1'b0);
      chk("wrap_words_sent_w", words_sent_w, 1);
      chk("wrap_words_sent", words_sent, 17);

      // Randomized entries and randomized sink readiness.
      for (int r = 0; r < 400; r++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) fifo_q.push_back($urandom);
         cycle($urandom_range(0, 3) != 0, 1'b1);
      end
      drain(200, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
- Downstream drain stage for the team's register FIFO (my_fifo).
- Pops entry_wd-bit entries from the FIFO and emits them as narrower out_wd-bit beats on a valid/ready stream, least significant beat first.
- Frames the beat stream into fixed-length packets with first/last markers.
- Keeps a wrapping count of fully transmitted entries for status readout.

Parameters:
- entry_wd, 32: FIFO entry width; must equal ratio*out_wd.
- out_wd, 8: output beat width.
- ratio, 4: beats per entry.
- beat_wd, 2: beat counter width; 2^beat_wd >= ratio.
- pkt_words, 4: entries per packet; must be >= 1.
- pkt_wd, 2: packet word counter width; 2^pkt_wd >= pkt_words.
- stat_wd, 16: width of the sent-entry counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst==0 resets).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  entry_wd  FIFO head entry; valid only while fifo_empty==0.
- fifo_rd  out  1  FIFO pop request; combinational.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  sink accepts the beat this cycle.
- out_data  out  out_wd  current beat.
- out_first  out  1  beat 0 of word 0 of a packet.
- out_last  out  1  final beat of the final word of a packet.
- busy  out  1  a word is held or the FIFO is non-empty.
- words_sent  out  stat_wd  entries fully transmitted, modulo 2^stat_wd.

Behaviour:
- Internal state:
  - hold_reg [entry_wd]
  - hold_valid
  - beat_cnt [beat_wd]
  - word_cnt [pkt_wd]
  - words_sent
- Reset (rst==0 at a clock edge):
  - hold_valid, beat_cnt, word_cnt and words_sent clear to 0; hold_reg may be left unreset.
  - Outputs after reset: out_valid=0, out_first=0, out_last=0, busy reflects fifo_empty only.
  - fifo_rd is forced 0 in every cycle rst==0.
  - A reset mid-word discards the held word and any remaining beats; no further FIFO pop occurs.
- Handshake:
  - Beat transfer (xfer) = out_valid && out_ready.
  - out_valid = hold_valid.
  - out_data, out_first and out_last stay stable while out_valid && !out_ready.
- Beat selection:
  - out_data = hold_reg[beat_cnt*out_wd +: out_wd].
- Pop rule (combinational):
  - last_beat = (beat_cnt == ratio-1).
  - fifo_rd = rst && !fifo_empty && (!hold_valid || (xfer && last_beat)).
- On a clock edge with fifo_rd=1:
  - hold_reg <= fifo_data; hold_valid <= 1; beat_cnt <= 0.
- On xfer && !last_beat:
  - beat_cnt <= beat_cnt+1.
- On xfer && last_beat:
  - words_sent <= words_sent+1 (wraps at 2^stat_wd).
  - word_cnt <= (word_cnt==pkt_words-1) ? 0 : word_cnt+1.
  - If fifo_rd is not also asserted in this cycle: hold_valid <= 0 and beat_cnt <= 0.
- Latency:
  - Entry present at the FIFO head (fifo_empty==0) at edge N-1 with the stage idle: fifo_rd is high during cycle N and out_valid is high from cycle N+1.
  - Back-to-back entries with out_ready held high give a continuous stream (one beat per cycle, no bubble between words).
- Framing:
  - out_first = hold_valid && beat_cnt==0 && word_cnt==0.
  - out_last = hold_valid && last_beat && word_cnt==pkt_words-1.
  - When pkt_words=1 and ratio=1, first and last may coincide.
- busy = hold_valid || !fifo_empty.
- The stage never pops while holding a word whose last beat is not being accepted, so FIFO underflow and data loss are impossible.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, fifo_empty=1 -> out_valid=0, fifo_rd=0, words_sent=0, busy=0.
- Single word: FIFO holds 32'hA1B2C3D4, out_ready=1 -> fifo_rd pulses one cycle; beats D4,C3,B2,A1 on 4 consecutive cycles, out_first on D4; words_sent=1.
- Packet framing: 8 words 0x00000000..0x00000007, out_ready=1 -> 32 beats with no gaps; out_first on beat 0 of words 0 and 4; out_last on beat 3 of words 3 and 7; words_sent=8.
- Backpressure: out_ready toggles 1,0,0,1 per cycle during word 32'h11223344 -> each beat held stable while out_ready=0; sequence 44,33,22,11 with no duplicates or skips; the next fifo_rd occurs only with the accepted beat 11.
- Reset mid-word: rst=0 after beat 2 of a word -> out_valid=0 next cycle, no fifo_rd during reset, word_cnt=0; the following FIFO entry is emitted with out_first=1.
- Counter wrap (stat_wd=4 override): 17 words sent -> words_sent reads 1.
